gate_op_scheduler: RTL and testbench



---
 rtl/gate_op_pkg.sv | 15 +
 rtl/bitwise_logic_unit.sv | 24 ++
 rtl/gate_op_scheduler.sv | 132 +++++++++++++
 tb/tb_gate_op_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_op_pkg.sv
// Shared definitions for the gate operation scheduler: opcodes and FSM state encoding.
package gate_op_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_NOT = 2'b10;
   localparam logic [1:0] OP_BUF = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/bitwise_logic_unit.sv
// Combinational W-bit bitwise unit: AND, OR, NOT, BUF selected by a 2-bit opcode.
module bitwise_logic_unit
   import gate_op_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [1:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NOT:  y = ~a;
         OP_BUF:  y = a;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/gate_op_scheduler.sv
// Round-robin scheduler sharing one bitwise logic unit between NREQ requesters,
// returning a registered result and requester ID over a valid/ready channel.
module gate_op_scheduler
   import gate_op_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [2*NREQ-1:0] req_op,
   input  logic [W*NREQ-1:0] req_a,
   input  logic [W*NREQ-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [W-1:0]      rsp_data,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        ops_done
);

   // Handshake: a request transfers in the IDLE cycle where req_valid[i] and
   // req_ready[i] are both high; a response transfers when rsp_valid and rsp_ready are high.

   state_t         state, state_nxt;
   logic [IDW-1:0] prio_ptr;
   logic [IDW-1:0] ptr_nxt;
   logic           grant_found;
   logic [IDW-1:0] grant_id;
   int             idx;

   logic [1:0]     sel_op;
   logic [W-1:0]   sel_a, sel_b;
   logic [1:0]     cap_op;
   logic [W-1:0]   cap_a, cap_b;
   logic [IDW-1:0] cap_id;
   logic [W-1:0]   alu_y;

   // Search upward from prio_ptr with wrap, first valid index wins.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      idx         = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(prio_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!grant_found && req_valid[idx[IDW-1:0]]) begin
            grant_found = 1'b1;
            grant_id    = idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_id == IDW'(i)) begin
            sel_op = req_op[2*i +: 2];
            sel_a  = req_a[W*i +: W];
            sel_b  = req_b[W*i +: W];
         end
      end
   end

   assign ptr_nxt   = (rsp_id == IDW'(NREQ-1)) ? '0 : rsp_id + IDW'(1);
   assign rsp_valid = (state == RESP);

   bitwise_logic_unit #(.W(W)) u_logic (
      .op (cap_op),
      .a  (cap_a),
      .b  (cap_b),
      .y  (alu_y)
   );

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (grant_found && rst_n) begin
               req_ready[grant_id] = 1'b1;
               state_nxt           = EXEC;
            end
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         prio_ptr <= '0;
         cap_op   <= '0;
         cap_a    <= '0;
         cap_b    <= '0;
         cap_id   <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
         ops_done <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (grant_found) begin
                  cap_op <= sel_op;
                  cap_a  <= sel_a;
                  cap_b  <= sel_b;
                  cap_id <= grant_id;
               end
            end
            EXEC: begin
               rsp_data <= alu_y;
               rsp_id   <= cap_id;
            end
            RESP: begin
               if (rsp_ready) begin
                  prio_ptr <= ptr_nxt;
                  if (ops_done != 8'hFF) ops_done <= ops_done + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Directed bench for gate_op_scheduler: drivers push expected responses, a
// negedge monitor pops and compares on every response handshake.
module tb_gate_op_scheduler;

   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int IDW  = 2;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [2*NREQ-1:0] req_op;
   logic [W*NREQ-1:0] req_a;
   logic [W*NREQ-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [W-1:0]      rsp_data;
   logic [IDW-1:0]    rsp_id;
   logic [7:0]        ops_done;

   logic [IDW+W-1:0]  exp_q[$];
   int                total = 0;
   int                bad   = 0;
   int                cyc   = 0;

   gate_op_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .ops_done  (ops_done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rsp_unexpected: got id=%0d data=%b, required no response", rsp_id, rsp_data);
         end else begin
            logic [IDW+W-1:0] e;
            e = exp_q.pop_front();
            if ({rsp_id, rsp_data} !== e) begin
               bad++;
               $display("FAIL rsp: got id=%0d data=%b, required id=%0d data=%b",
                        rsp_id, rsp_data, e[IDW+W-1:W], e[W-1:0]);
            end
         end
      end
   end

   // driver tasks
   task automatic set_req(input int id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      req_op[2*id +: 2] = op;
      req_a[W*id +: W]  = a;
      req_b[W*id +: W]  = b;
   endtask

   task automatic push_exp(input int id, input logic [3:0] y);
      logic [IDW-1:0] idl;
      idl = IDW'(id);
      exp_q.push_back({idl, y});
   endtask

   task automatic wait_grant(input int id);
      logic [NREQ-1:0] oh;
      oh = 4'b0001 << id;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (req_ready[id]) break;
      end
      check("grant", req_ready, oh);
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic issue_one(input int id, input logic [1:0] op, input logic [3:0] a,
                            input logic [3:0] b, input logic [3:0] y, input bit push);
      set_req(id, op, a, b);
      if (push) push_exp(id, y);
      req_valid[id] = 1'b1;
      wait_grant(id);
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 60; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [1:0] t2_op [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
   logic [3:0] t2_b  [6] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b1111, 4'b1111};
   logic [3:0] t2_y  [6] = '{4'b0010, 4'b0111, 4'b1001, 4'b0110, 4'b1001, 4'b0110};
   int         rr_order [5] = '{0, 1, 2, 3, 0};
   logic [3:0] rr_y     [5] = '{4'b0101, 4'b1001, 4'b1100, 4'b1010, 4'b0101};

   initial begin
      int last;
      logic [NREQ-1:0] oh;
      rst_n     = 1'b0;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      // reset values
      #2;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_ops_done", ops_done, 0);
      check("rst_req_ready", req_ready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // single AND request with latency check
      issue_one(0, 2'b00, 4'b1100, 4'b1010, 4'b1000, 1);
      @(negedge clk);
      check("lat_t1_valid", rsp_valid, 0);
      @(negedge clk);
      check("lat_t2_valid", rsp_valid, 1);
      @(posedge clk);
      @(negedge clk);
      check("ops_done_1", ops_done, 1);
      @(posedge clk);
      #1;

      // all opcodes on requester 2, B ignored for NOT/BUF
      for (int i = 0; i < 6; i++) issue_one(2, t2_op[i], 4'b0110, t2_b[i], t2_y[i], 1);
      wait_drain();
      check("ops_done_7", ops_done, 7);

      // round robin from a fresh pointer
      do_reset();
      set_req(0, 2'b00, 4'b1111, 4'b0101);
      set_req(1, 2'b01, 4'b1000, 4'b0001);
      set_req(2, 2'b10, 4'b0011, 4'b0000);
      set_req(3, 2'b11, 4'b1010, 4'b0000);
      for (int g = 0; g < 5; g++) push_exp(rr_order[g], rr_y[g]);
      req_valid = 4'b1111;
      last = 0;
      for (int g = 0; g < 5; g++) begin
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready != 0) break;
         end
         oh = 4'b0001 << rr_order[g];
         check("rr_grant", req_ready, oh);
         if (g > 0) check("rr_gap", cyc - last, 3);
         last = cyc;
         @(posedge clk);
         #1;
         if (g == 4) req_valid = '0;
      end
      wait_drain();

      // backpressure on requester 1 while requester 3 waits
      rsp_ready = 1'b0;
      issue_one(1, 2'b01, 4'b0100, 4'b0010, 4'b0110, 1);
      set_req(3, 2'b11, 4'b0111, 4'b0000);
      push_exp(3, 4'b0111);
      req_valid[3] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", rsp_valid, 1);
         check("bp_data", rsp_data, 4'b0110);
         check("bp_id", rsp_id, 1);
         check("bp_req_ready", req_ready, 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", rsp_valid, 1);
      @(negedge clk);
      check("bp_after_valid", rsp_valid, 0);
      check("bp_next_grant", req_ready, 4'b1000);
      @(posedge clk);
      #1;
      req_valid[3] = 1'b0;
      wait_drain();

      // reset during EXEC aborts the transaction and clears the pointer
      issue_one(1, 2'b00, 4'b1100, 4'b0110, 4'b0100, 1);
      wait_drain();
      issue_one(2, 2'b00, 4'b1111, 4'b1111, 4'b1111, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", rsp_valid, 0);
      check("mid_rst_data", rsp_data, 0);
      check("mid_rst_id", rsp_id, 0);
      check("mid_rst_ops", ops_done, 0);
      check("mid_rst_ready", req_ready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("post_rst_valid", rsp_valid, 0);
      end
      @(posedge clk);
      #1;
      set_req(1, 2'b10, 4'b0101, 4'b0000);
      set_req(3, 2'b11, 4'b0001, 4'b0000);
      push_exp(1, 4'b1010);
      push_exp(3, 4'b0001);
      req_valid = 4'b1010;
      wait_grant(1);
      wait_grant(3);
      wait_drain();
      check("post_rst_ops", ops_done, 2);

      // saturation of ops_done
      do_reset();
      for (int n = 0; n < 255; n++) issue_one(0, 2'b11, 4'b0101, 4'b0000, 4'b0101, 1);
      wait_drain();
      check("sat_255", ops_done, 255);
      for (int n = 0; n < 5; n++) issue_one(0, 2'b11, 4'b0101, 4'b0000, 4'b0101, 1);
      wait_drain();
      check("sat_hold", ops_done, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
